// File: rtl/sram_pkg.sv
// Shared constants for the 32K x 8 synchronous SRAM and its burst front-end.
package sram_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Address increment wraps naturally at the top of the SRAM.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Request, write-stream, read-stream and SRAM pin bundle for sram_burst_ctrl.
interface sram_burst_ctrl_if;
    import sram_pkg::*;

    logic              Req_valid;
    logic              Req_ready;
    logic              Req_rw;
    logic [ADDR_W-1:0] Req_addr;
    logic [LEN_W-1:0]  Req_len;
    logic [DATA_W-1:0] Wr_data;
    logic              Wr_valid;
    logic              Wr_ready;
    logic [DATA_W-1:0] Rd_data;
    logic              Rd_valid;
    logic              Done;
    logic              Mem_en;
    logic              Mem_rw;
    logic [ADDR_W-1:0] Mem_addr;
    logic [DATA_W-1:0] Mem_wdata;
    logic [DATA_W-1:0] Mem_rdata;

    // Master is the requester plus the SRAM data return.
    modport master (
        output Req_valid, Req_rw, Req_addr, Req_len, Wr_data, Wr_valid, Mem_rdata,
        input  Req_ready, Wr_ready, Rd_data, Rd_valid, Done,
               Mem_en, Mem_rw, Mem_addr, Mem_wdata
    );

    modport slave (
        input  Req_valid, Req_rw, Req_addr, Req_len, Wr_data, Wr_valid, Mem_rdata,
        output Req_ready, Wr_ready, Rd_data, Rd_valid, Done,
               Mem_en, Mem_rw, Mem_addr, Mem_wdata
    );

endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer: turns one read/write burst request into per-byte SRAM
// accesses and returns read bytes one cycle after issue.
module sram_burst_ctrl
    import sram_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    sram_burst_ctrl_if.slave  bus
);

    logic [1:0]        state_reg,   state_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [LEN_W-1:0]  count_reg,   count_next;
    logic              rd_pend_reg, rd_pend_next;
    logic              done_reg,    done_next;
    logic              wr_fire;
    logic              rd_issue;
    logic              active;
    logic [DATA_W-1:0] rd_data;

    assign wr_fire  = (state_reg == WRITE) && bus.Wr_valid;
    assign rd_issue = (state_reg == READ);
    assign active   = (state_reg == WRITE) || (state_reg == READ);

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        count_next   = count_reg;
        rd_pend_next = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.Req_valid) begin
                    addr_next  = bus.Req_addr;
                    count_next = bus.Req_len;
                    state_next = (bus.Req_rw == RW_WRITE) ? WRITE : READ;
                end
            end
            WRITE: begin
                if (bus.Wr_valid) begin
                    addr_next = addr_inc(addr_reg);
                    if (count_reg == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
            end
            READ: begin
                rd_pend_next = 1'b1;
                addr_next    = addr_inc(addr_reg);
                if (count_reg == '0) begin
                    state_next = DRAIN;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            count_reg   <= '0;
            rd_pend_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            count_reg   <= count_next;
            rd_pend_reg <= rd_pend_next;
            done_reg    <= done_next;
        end
    end

    // Handshakes are withheld during reset so nothing is consumed and lost.
    assign bus.Req_ready = !Rst && (state_reg == IDLE);
    assign bus.Wr_ready  = !Rst && (state_reg == WRITE);

    assign bus.Mem_en    = !Rst && (wr_fire || rd_issue);
    assign bus.Mem_rw    = !Rst && (state_reg == WRITE);
    assign bus.Mem_addr  = (!Rst && active) ? addr_reg : '0;
    assign bus.Mem_wdata = (!Rst && (state_reg == WRITE)) ? bus.Wr_data : '0;

    // SRAM output is only meaningful the cycle after a read issue.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rd_mask
        assign rd_data[gi] = bus.Mem_rdata[gi] & rd_pend_reg;
    end

    assign bus.Rd_valid = rd_pend_reg;
    assign bus.Rd_data  = rd_data;
    // Read completion coincides with the last returned byte in DRAIN.
    assign bus.Done     = done_reg || (state_reg == DRAIN);

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl with an attached SRAM model and a
// byte-array reference of the expected memory contents.
module tb_sram_burst_ctrl;
    import sram_pkg::*;

    localparam int MEM_SIZE = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] a;
        int                l;
    } burst_t;

    logic Clk = 1'b0;
    logic Rst;

    sram_burst_ctrl_if bus();

    sram_burst_ctrl dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // SRAM: registered read, write on enable.
    logic [DATA_W-1:0] sram [MEM_SIZE];
    always @(posedge Clk) begin
        if (bus.Mem_en) begin
            if (bus.Mem_rw) sram[bus.Mem_addr] <= bus.Mem_wdata;
            else            bus.Mem_rdata      <= sram[bus.Mem_addr];
        end
    end

    logic [DATA_W-1:0] ref_mem [MEM_SIZE];
    logic [DATA_W-1:0] wbuf [256];
    burst_t            wq [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Req_valid = 1'b0;
        bus.Req_rw    = 1'b0;
        bus.Req_addr  = '0;
        bus.Req_len   = '0;
        bus.Wr_valid  = 1'b0;
        bus.Wr_data   = '0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input int len_m1,
                            input logic [31:0] vpat, input int vpat_len, input bit rnd_stall);
        int L;
        int i;
        int c;
        logic wv;
        logic [ADDR_W-1:0] ea;
        L = len_m1 + 1;
        i = 0;
        c = 0;
        @(negedge Clk);
        bus.Req_valid = 1'b1;
        bus.Req_rw    = 1'b1;
        bus.Req_addr  = a;
        bus.Req_len   = 8'(len_m1);
        bus.Wr_valid  = 1'b0;
        #1;
        chk("wr_req_ready", 32'(bus.Req_ready), 1);
        chk("wr_req_mem_en", 32'(bus.Mem_en), 0);
        while (i < L) begin
            @(negedge Clk);
            bus.Req_valid = 1'b0;
            bus.Req_addr  = 15'($urandom);
            if (c < vpat_len)   wv = vpat[c];
            else if (rnd_stall) wv = ($urandom_range(0, 3) != 0);
            else                wv = 1'b1;
            bus.Wr_valid = wv;
            bus.Wr_data  = wv ? wbuf[i] : 8'($urandom);
            #1;
            ea = a + 15'(i);
            chk("wr_ready", 32'(bus.Wr_ready), 1);
            chk("wr_mem_en", 32'(bus.Mem_en), 32'(wv));
            chk("wr_done_early", 32'(bus.Done), 0);
            chk("wr_busy", 32'(bus.Req_ready), 0);
            if (wv) begin
                chk("wr_mem_rw", 32'(bus.Mem_rw), 1);
                chk("wr_mem_addr", 32'(bus.Mem_addr), 32'(ea));
                chk("wr_mem_wdata", 32'(bus.Mem_wdata), 32'(wbuf[i]));
                ref_mem[ea] = wbuf[i];
                i++;
            end
            c++;
            if (c > 4 * L + 40) begin
                chk("wr_timeout", 32'(i), 32'(L));
                break;
            end
        end
        @(negedge Clk);
        bus.Wr_valid = 1'b0;
        #1;
        chk("wr_done", 32'(bus.Done), 1);
        chk("wr_done_req_ready", 32'(bus.Req_ready), 1);
        chk("wr_done_mem_en", 32'(bus.Mem_en), 0);
        chk("wr_done_wr_ready", 32'(bus.Wr_ready), 0);
        @(negedge Clk);
        #1;
        chk("wr_done_once", 32'(bus.Done), 0);
        $display("write burst addr=%h bytes=%0d cycles=%0d", a, L, c);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int len_m1, input bit skip_req,
                           input bit hold_next, input logic [ADDR_W-1:0] na, input int nlen_m1);
        int L;
        logic [ADDR_W-1:0] ea;
        L = len_m1 + 1;
        if (!skip_req) begin
            @(negedge Clk);
            bus.Req_valid = 1'b1;
            bus.Req_rw    = 1'b0;
            bus.Req_addr  = a;
            bus.Req_len   = 8'(len_m1);
            #1;
            chk("rd_req_ready", 32'(bus.Req_ready), 1);
            chk("rd_req_mem_en", 32'(bus.Mem_en), 0);
            chk("rd_req_rd_valid", 32'(bus.Rd_valid), 0);
        end
        for (int i = 0; i < L; i++) begin
            @(negedge Clk);
            bus.Req_valid = hold_next;
            bus.Req_rw    = 1'b0;
            bus.Req_addr  = na;
            bus.Req_len   = 8'(nlen_m1);
            bus.Wr_valid  = 1'($urandom);
            bus.Wr_data   = 8'($urandom);
            #1;
            ea = a + 15'(i);
            chk("rd_mem_en", 32'(bus.Mem_en), 1);
            chk("rd_mem_rw", 32'(bus.Mem_rw), 0);
            chk("rd_mem_addr", 32'(bus.Mem_addr), 32'(ea));
            chk("rd_wr_ready", 32'(bus.Wr_ready), 0);
            chk("rd_busy", 32'(bus.Req_ready), 0);
            chk("rd_done_early", 32'(bus.Done), 0);
            if (i == 0) begin
                chk("rd_first_valid", 32'(bus.Rd_valid), 0);
                chk("rd_first_data", 32'(bus.Rd_data), 0);
            end else begin
                chk("rd_valid", 32'(bus.Rd_valid), 1);
                chk("rd_data", 32'(bus.Rd_data), 32'(ref_mem[ea - 15'd1]));
            end
        end
        @(negedge Clk);
        bus.Wr_valid = 1'b0;
        #1;
        ea = a + 15'(L - 1);
        chk("rd_drain_mem_en", 32'(bus.Mem_en), 0);
        chk("rd_last_valid", 32'(bus.Rd_valid), 1);
        chk("rd_last_data", 32'(bus.Rd_data), 32'(ref_mem[ea]));
        chk("rd_done", 32'(bus.Done), 1);
        chk("rd_drain_busy", 32'(bus.Req_ready), 0);
        @(negedge Clk);
        #1;
        chk("rd_idle_valid", 32'(bus.Rd_valid), 0);
        chk("rd_idle_data", 32'(bus.Rd_data), 0);
        chk("rd_idle_done", 32'(bus.Done), 0);
        chk("rd_idle_ready", 32'(bus.Req_ready), 1);
        chk("rd_idle_mem_en", 32'(bus.Mem_en), 0);
        $display("read burst addr=%h bytes=%0d held_next=%0d", a, L, hold_next);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        int rl;
        int j;

        Rst = 1'b1;
        idle_inputs();
        @(negedge Clk);
        #1;
        chk("rst_mem_en", 32'(bus.Mem_en), 0);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        chk("rst_req_ready", 32'(bus.Req_ready), 1);
        chk("rst_wr_ready", 32'(bus.Wr_ready), 0);
        chk("rst_rd_valid", 32'(bus.Rd_valid), 0);
        chk("rst_rd_data", 32'(bus.Rd_data), 0);
        chk("rst_done", 32'(bus.Done), 0);
        $display("reset released");

        // 4-byte write at 0x0010 and readback
        wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
        do_write(15'h0010, 3, 32'd0, 0, 1'b0);
        do_read(15'h0010, 3, 1'b0, 1'b0, 15'd0, 0);

        // Wrap across the top of the address space
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(15'h7FFE, 2, 32'd0, 0, 1'b0);
        do_read(15'h7FFE, 2, 1'b0, 1'b0, 15'd0, 0);

        // Write stall pattern 1,0,0,1
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        do_write(15'h0200, 1, 32'b1001, 4, 1'b0);

        // Second request held during a read burst, accepted in first IDLE cycle
        do_read(15'h0010, 3, 1'b0, 1'b1, 15'h7FFE, 2);
        do_read(15'h7FFE, 2, 1'b1, 1'b0, 15'd0, 0);
        do_read(15'h0200, 1, 1'b0, 1'b0, 15'd0, 0);

        // Single-byte and maximum-length bursts
        wbuf[0] = 8'h9E;
        do_write(15'h7FFF, 0, 32'd0, 0, 1'b0);
        do_read(15'h7FFF, 0, 1'b0, 1'b0, 15'd0, 0);
        for (int k = 0; k < 256; k++) wbuf[k] = 8'($urandom);
        do_write(15'h4000, 255, 32'd0, 0, 1'b1);
        do_read(15'h4000, 255, 1'b0, 1'b0, 15'd0, 0);
        wq.push_back('{a: 15'h4000, l: 255});
        wq.push_back('{a: 15'h7FFE, l: 2});

        // Reset during the 2nd issue of an 8-byte read
        @(negedge Clk);
        bus.Req_valid = 1'b1;
        bus.Req_rw    = 1'b0;
        bus.Req_addr  = 15'h0010;
        bus.Req_len   = 8'd7;
        #1;
        chk("mid_req_ready", 32'(bus.Req_ready), 1);
        @(negedge Clk);
        bus.Req_valid = 1'b0;
        #1;
        chk("mid_issue1", 32'(bus.Mem_en), 1);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("mid_rst_mem_en", 32'(bus.Mem_en), 0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("mid_after_ready", 32'(bus.Req_ready), 1);
        for (int k = 0; k < 10; k++) begin
            chk("mid_after_mem_en", 32'(bus.Mem_en), 0);
            chk("mid_after_rd_valid", 32'(bus.Rd_valid), 0);
            chk("mid_after_done", 32'(bus.Done), 0);
            @(negedge Clk);
            #1;
        end
        $display("reset mid-read aborted");

        // Randomized bursts checked against the reference contents
        for (int k = 0; k < 24; k++) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 1) begin
                ra = 15'($urandom);
                rl = $urandom_range(0, 15);
                for (int b = 0; b <= rl; b++) wbuf[b] = 8'($urandom);
                do_write(ra, rl, 32'd0, 0, 1'b1);
                wq.push_back('{a: ra, l: rl});
            end else begin
                j = $urandom_range(0, wq.size() - 1);
                do_read(wq[j].a, wq[j].l, 1'b0, 1'b0, 15'd0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
